param_stream_tx: RTL and testbench
==================================

Name: param_stream_tx

Overview:
- Host-side transmitter that drives the neural-network core's byte-stream load interface.
- Holds a local image of all perceptron parameters and the four input bytes, written over a simple host port.
- On `start`, streams the image out one byte per accepted beat and emits one-cycle phase-change strobes that step the core's mode machine through PARAMS -> INPUTS -> RUN -> READ.
- Sits between the host/test controller and the core's `ui_in`/control pins.

Parameters:
- N_PARAMS, 24, parameter bytes in the image (4 neurons x {w0,w1,w2,w3,bias,threshold}).
- N_INPUTS, 4, input bytes sent in the INPUTS phase.
- RUN_CYCLES, 4, clocks held in the RUN phase before the final strobe (must be >= 1).
- DW, 8, byte width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  host write strobe into the image.
- wr_addr  in  5  image address: 0..N_PARAMS-1 = params; N_PARAMS..N_PARAMS+N_INPUTS-1 = inputs.
- wr_data  in  DW  host write data.
- start  in  1  one-cycle request to begin a transfer.
- out_ready  in  1  core/link accepts the current byte this cycle.
- data_out  out  DW  byte presented to the core.
- data_valid  out  1  data_out is valid this cycle.
- phase_chg  out  1  one-cycle strobe that advances the core's mode machine.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when the transfer completes.

Behaviour:
- Reset (async assert): state=IDLE; data_out=0, data_valid=0, phase_chg=0, busy=0, done=0; image and counters cleared to 0. Reset mid-transfer aborts the transfer with no further strobes.
- Image writes:
  - A write lands on the rising edge when wr_en=1, busy=0 and wr_addr < N_PARAMS+N_INPUTS.
  - Out-of-range writes, and any write while busy=1, are ignored.
- Parameter byte order: param index = 6*n + k. k=0..3 are weights w_n0..w_n3, k=4 is bias, k=5 is threshold. Index 0 is sent first.
- States: IDLE, PARAMS, CHG1, INPUTS, CHG2, RUN, CHG3, DONE.
- IDLE:
  - start=1 -> PARAMS next cycle; idx=0; busy=1 from that cycle.
  - start while busy is ignored.
  - start and wr_en in the same IDLE cycle: the write lands first, so the transfer uses the new byte.
- PARAMS:
  - data_valid=1 and data_out=image[idx], both registered.
  - A beat transfers when data_valid & out_ready; idx increments only on a transfer.
  - out_ready=0 holds data_out and data_valid stable (no drop, no repeat).
  - After the transfer of idx=N_PARAMS-1 -> CHG1.
- CHG1: data_valid=0, phase_chg=1 for exactly one cycle -> INPUTS with idx=0.
- INPUTS: same beat rules as PARAMS over image[N_PARAMS+idx]; after the last beat -> CHG2.
- CHG2: data_valid=0, phase_chg=1 for one cycle -> RUN.
- RUN: data_valid=0; hold exactly RUN_CYCLES clocks, ignoring out_ready -> CHG3.
- CHG3: phase_chg=1 for one cycle -> DONE.
- DONE: done=1 for one cycle, busy=0 in the same cycle -> IDLE.
- Latency and strobes:
  - With out_ready held high, first data_valid appears 1 cycle after start is sampled.
  - Total cycles from the start edge to the done pulse = N_PARAMS + N_INPUTS + RUN_CYCLES + 4.
  - phase_chg never coincides with data_valid. There are exactly 3 strobes per transfer.
- Counters: idx is 5 bits and wraps only via the state transition, never arithmetically. The RUN counter is wide enough for RUN_CYCLES.

Test Plan:
- Write image[i]=i+1 for i=0..27; start with out_ready=1 -> bytes 0x01..0x18 on consecutive cycles; phase_chg; 0x19..0x1C; phase_chg; 4 idle cycles; phase_chg; done. Total 36 cycles from start to done.
- Same image; out_ready toggles 1,0,1,0 -> every byte appears exactly once in order; data_out stays stable during stalls; phase_chg count = 3.
- Write wr_addr=5 with 0xAA while busy; write wr_addr=30 while idle -> the next transfer sends the previously written value at index 5; nothing changes for addr 30.
- Pulse start again during PARAMS at idx=10 -> no restart; sequence identical to the single-start run; exactly one done.
- Assert reset during INPUTS (idx=2) -> all outputs 0 immediately; after release, start sends all-zero bytes (image cleared).
- start and wr_en(addr 0, 0x7F) in the same IDLE cycle -> first transmitted byte is 0x7F.

Source files
------------

// File: rtl/param_stream_tx.sv
// Host-side transmitter: holds a parameter/input image and streams it to the core
// byte by byte, stepping the core's mode machine with one-cycle phase_chg strobes.
module param_stream_tx #(
  parameter int N_PARAMS   = 24,
  parameter int N_INPUTS   = 4,
  parameter int RUN_CYCLES = 4,
  parameter int DW         = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [4:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          out_ready,
  output logic [DW-1:0] data_out,
  output logic          data_valid,
  output logic          phase_chg,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);

  localparam int N_TOTAL = N_PARAMS + N_INPUTS;
  localparam int RW      = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  // Handshake: a byte moves on a rising edge where data_valid && out_ready; while
  // out_ready is low the presented byte and data_valid hold unchanged.
  typedef enum logic [2:0] {
    S_IDLE, S_PARAMS, S_CHG1, S_INPUTS, S_CHG2, S_RUN, S_CHG3, S_DONE
  } state_t;

  state_t        r_state, w_state_next;
  logic [4:0]    r_idx, w_idx_next;
  logic [RW-1:0] r_run_cnt, w_run_cnt_next;
  logic [DW-1:0] r_image [N_TOTAL];
  logic [DW-1:0] r_data_out, w_data_out_next;
  logic          r_data_valid, w_data_valid_next;
  logic          w_busy;
  logic          w_wr_ok;
  logic          w_beat;
  logic [4:0]    w_param_rd;
  logic [4:0]    w_input_rd;

  assign w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_wr_ok    = wr_en && !w_busy && ({1'b0, wr_addr} < 6'(N_TOTAL));
  assign w_beat     = r_data_valid && out_ready;
  assign w_param_rd = r_idx + 5'd1;
  assign w_input_rd = 5'(N_PARAMS) + r_idx + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_TOTAL; i++) r_image[i] <= '0;
    end else if (w_wr_ok) begin
      r_image[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_run_cnt_next    = r_run_cnt;
    w_data_out_next   = r_data_out;
    w_data_valid_next = r_data_valid;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next      = S_PARAMS;
          w_idx_next        = '0;
          w_data_valid_next = 1'b1;
          // A same-cycle host write to byte 0 must be what goes out first.
          w_data_out_next   = (w_wr_ok && (wr_addr == 5'd0)) ? wr_data : r_image[0];
        end
      end
      S_PARAMS: begin
        if (w_beat) begin
          if (r_idx == 5'(N_PARAMS - 1)) begin
            w_state_next      = S_CHG1;
            w_idx_next        = '0;
            w_data_valid_next = 1'b0;
            w_data_out_next   = '0;
          end else begin
            w_idx_next      = w_param_rd;
            w_data_out_next = r_image[w_param_rd];
          end
        end
      end
      S_CHG1: begin
        w_state_next      = S_INPUTS;
        w_idx_next        = '0;
        w_data_valid_next = 1'b1;
        w_data_out_next   = r_image[N_PARAMS];
      end
      S_INPUTS: begin
        if (w_beat) begin
          if (r_idx == 5'(N_INPUTS - 1)) begin
            w_state_next      = S_CHG2;
            w_idx_next        = '0;
            w_data_valid_next = 1'b0;
            w_data_out_next   = '0;
          end else begin
            w_idx_next      = r_idx + 5'd1;
            w_data_out_next = r_image[w_input_rd];
          end
        end
      end
      S_CHG2: begin
        w_state_next   = S_RUN;
        w_run_cnt_next = '0;
      end
      S_RUN: begin
        if (r_run_cnt == RW'(RUN_CYCLES - 1)) begin
          w_state_next = S_CHG3;
        end else begin
          w_run_cnt_next = r_run_cnt + 1'b1;
        end
      end
      S_CHG3:  w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_run_cnt    <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_run_cnt    <= w_run_cnt_next;
      r_data_out   <= w_data_out_next;
      r_data_valid <= w_data_valid_next;
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign phase_chg  = (r_state == S_CHG1) || (r_state == S_CHG2) || (r_state == S_CHG3);
  assign busy       = w_busy;
  assign done       = (r_state == S_DONE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_param_stream_tx.sv
// Testbench for param_stream_tx: directed and randomized transfers checked against
// an event log predicted from a model of the image contents.
module tb_param_stream_tx;

  localparam int P  = 24;
  localparam int I  = 4;
  localparam int R  = 4;
  localparam int NT = P + I;
  localparam logic [9:0] TOK_CHG  = 10'h100;
  localparam logic [9:0] TOK_DONE = 10'h200;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       out_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       phase_chg;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  int n_asserts = 0;
  int n_fail    = 0;

  logic [7:0] model_img [NT];
  logic [9:0] exp_q[$];
  logic [9:0] got_q[$];
  int         strobe_cyc[$];
  int         done_cyc;
  int         done_cnt;

  always #5 clk = ~clk;

  param_stream_tx #(.N_PARAMS(P), .N_INPUTS(I), .RUN_CYCLES(R), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .out_ready (out_ready),
    .data_out  (data_out),
    .data_valid(data_valid),
    .phase_chg (phase_chg),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (int'(a) < NT) model_img[a] = d;
  endtask

  // Expected log: every parameter byte, strobe, every input byte, two strobes, done.
  function automatic void build_expected();
    exp_q.delete();
    for (int i = 0; i < P; i++) exp_q.push_back({2'b00, model_img[i]});
    exp_q.push_back(TOK_CHG);
    for (int i = 0; i < I; i++) exp_q.push_back({2'b00, model_img[P+i]});
    exp_q.push_back(TOK_CHG);
    exp_q.push_back(TOK_CHG);
    exp_q.push_back(TOK_DONE);
  endfunction

  // mode 0: out_ready always 1; 1: toggles 1,0,1,0; 2: random.
  task automatic run_transfer(input string name, input int mode, input int restart_at,
                              input int busy_wr_at, input bit wr_with_start,
                              input logic [7:0] start_byte, input bit check_timing);
    int cyc, tail, n;
    bit prev_stall;
    logic [7:0] prev_data;
    got_q.delete(); strobe_cyc.delete();
    done_cyc = 0; done_cnt = 0; prev_stall = 0; prev_data = '0; tail = -1;
    @(negedge clk);
    start = 1'b1;
    if (wr_with_start) begin
      wr_en = 1'b1; wr_addr = 5'd0; wr_data = start_byte; model_img[0] = start_byte;
    end
    build_expected();
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    cyc = 1;
    while (cyc <= 400 && tail != 0) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = cyc[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      start = (cyc == restart_at);
      wr_en = (cyc == busy_wr_at);
      if (cyc == busy_wr_at) begin wr_addr = 5'd5; wr_data = 8'hAA; end
      if (prev_stall)
        check($sformatf("%s stall_hold c%0d", name, cyc), {data_valid, data_out}, {1'b1, prev_data});
      check($sformatf("%s chg_vs_valid c%0d", name, cyc), 32'(phase_chg & data_valid), 32'd0);
      if (data_valid && out_ready) got_q.push_back({2'b00, data_out});
      if (phase_chg) begin got_q.push_back(TOK_CHG); strobe_cyc.push_back(cyc); end
      if (done) begin
        got_q.push_back(TOK_DONE);
        done_cnt++;
        done_cyc = cyc;
        check($sformatf("%s busy_at_done", name), 32'(busy), 32'd0);
        if (tail < 0) tail = 4;
      end
      prev_stall = data_valid && !out_ready;
      prev_data  = data_out;
      if (tail > 0) tail--;
      if (tail != 0) begin @(negedge clk); cyc++; end
    end
    start = 1'b0; wr_en = 1'b0;
    check($sformatf("%s done_count", name), done_cnt, 1);
    check($sformatf("%s log_len", name), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s log[%0d]", name, i), 32'(got_q[i]), 32'(exp_q[i]));
    check($sformatf("%s strobe_count", name), strobe_cyc.size(), 3);
    if (strobe_cyc.size() == 3)
      check($sformatf("%s run_gap", name), strobe_cyc[2] - strobe_cyc[1], R + 1);
    if (check_timing) begin
      check($sformatf("%s done_latency", name), done_cyc, P + I + R + 4);
      if (strobe_cyc.size() == 3) begin
        check($sformatf("%s chg1_cycle", name), strobe_cyc[0], P + 1);
        check($sformatf("%s chg2_cycle", name), strobe_cyc[1], P + I + 2);
      end
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < NT; i++) model_img[i] = 8'h00;
    repeat (2) @(negedge clk);
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset data_valid", 32'(data_valid), 32'd0);
    check("reset phase_chg", 32'(phase_chg), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NT; i++) host_write(5'(i), 8'(i + 1));
    run_transfer("ramp_full", 0, 0, 0, 1'b0, 8'h00, 1'b1);
    run_transfer("ramp_toggle", 1, 0, 0, 1'b0, 8'h00, 1'b0);

    run_transfer("busy_write", 0, 0, 3, 1'b0, 8'h00, 1'b1);
    host_write(5'd30, 8'h55);
    run_transfer("after_ignored", 0, 0, 0, 1'b0, 8'h00, 1'b1);

    run_transfer("restart_ignored", 0, 11, 0, 1'b0, 8'h00, 1'b1);

    // Abort in INPUTS while input byte 2 is on the bus.
    @(negedge clk);
    start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 28; c++) @(negedge clk);
    check("rst_pre_valid", 32'(data_valid), 32'd1);
    check("rst_pre_byte", 32'(data_out), 32'(model_img[P+2]));
    #2 reset = 1'b1;
    #1 check("rst_async_outputs", {data_out, data_valid, phase_chg, busy, done}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_quiet", {phase_chg, done, data_valid, busy}, 32'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < NT; i++) model_img[i] = 8'h00;
    run_transfer("zero_image", 0, 0, 0, 1'b0, 8'h00, 1'b1);

    run_transfer("write_with_start", 0, 0, 0, 1'b1, 8'h7F, 1'b1);

    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < NT; a++) host_write(5'(a), 8'($urandom_range(0, 255)));
      run_transfer($sformatf("random%0d", k), 2, 0, 0, 1'b0, 8'h00, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
